act_buffer_ring: RTL and testbench

- N-bank ring activation buffer. Generalises the 2-bank ping-pong activation SRAM to NUM_BANKS banks.
- Bank ownership is tracked in hardware: DMA producer commits filled banks, systolic-array consumer releases drained banks. No external bank_sel.
- Adds per-element write strobes, overflow/underflow error flags, and an optional output pipeline stage.
- Sits between the DMA write path and the systolic array A-operand input.

---
 rtl/act_buf_pkg.sv | 17 +
 rtl/act_buf_bank_ctrl.sv | 66 ++++++
 rtl/act_buffer_ring.sv | 110 +++++++++++
 tb/tb_act_buffer_ring.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_buf_pkg.sv
// Shared configuration and types for the ring activation buffer.
// The buffer geometry is set here. NUM_BANKS must be a power of two
// between 2 and 16.
package act_buf_pkg;
  localparam int TM         = 14;
  localparam int ELEM_W     = 8;
  localparam int ADDR_WIDTH = 7;
  localparam int NUM_BANKS  = 4;

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int ROW_W  = TM * ELEM_W;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CNT_W  = BANK_W + 1;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [TM-1:0]    row_t;
endpackage

// File: rtl/act_buf_bank_ctrl.sv
// Bank ownership tracker for the ring activation buffer.
// The DMA side commits filled banks and the array side releases drained
// banks. A rejected request raises a one-cycle error pulse.
module act_buf_bank_ctrl
  import act_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic              rd_release,
  output logic              wr_ready,
  output logic              rd_avail,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic [CNT_W-1:0]  full_cnt,
  output logic              err_wr_drop,
  output logic              err_rd_drop
);

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  full_cnt_q, full_cnt_d;
  logic              err_wr_drop_q, err_wr_drop_d;
  logic              err_rd_drop_q, err_rd_drop_d;
  logic              commit_ok, release_ok;

  assign wr_ready = (full_cnt_q < CNT_W'(NUM_BANKS));
  assign rd_avail = (full_cnt_q != '0);

  // Next-state logic. Pointers wrap naturally because NUM_BANKS is a power of two.
  always_comb begin
    commit_ok     = wr_commit & wr_ready;
    release_ok    = rd_release & rd_avail;
    wr_bank_d     = wr_bank_q + BANK_W'(commit_ok);
    rd_bank_d     = rd_bank_q + BANK_W'(release_ok);
    full_cnt_d    = full_cnt_q + CNT_W'(commit_ok) - CNT_W'(release_ok);
    err_wr_drop_d = (wr_en | wr_commit) & ~wr_ready;
    err_rd_drop_d = (rd_en | rd_release) & ~rd_avail;
  end

  // Ownership state. Reset returns every bank to the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q     <= '0;
      rd_bank_q     <= '0;
      full_cnt_q    <= '0;
      err_wr_drop_q <= 1'b0;
      err_rd_drop_q <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_cnt_q    <= full_cnt_d;
      err_wr_drop_q <= err_wr_drop_d;
      err_rd_drop_q <= err_rd_drop_d;
    end
  end

  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign full_cnt    = full_cnt_q;
  assign err_wr_drop = err_wr_drop_q;
  assign err_rd_drop = err_rd_drop_q;

endmodule

// File: rtl/act_buffer_ring.sv
// N-bank ring activation buffer between the DMA write path and the
// systolic-array A operand. The macro ACT_BUF_OUT_REG_EN adds a second
// read register, which gives a read latency of two cycles. Without it the
// read latency is one cycle.
module act_buffer_ring
  import act_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ROW_W-1:0]      wr_data,
  input  logic [TM-1:0]         wr_strb,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [ROW_W-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [CNT_W-1:0]      full_cnt,
  output logic                  err_wr_drop,
  output logic                  err_rd_drop
);

  row_t mem_q [NUM_BANKS][DEPTH];
  row_t wr_row;
  logic wr_fire;
  logic rd_fire;
  row_t rd_row_p1_q, rd_row_p1_d;
  logic vld_p1_q, vld_p1_d;

  act_buf_bank_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_commit   (wr_commit),
    .rd_en       (rd_en),
    .rd_release  (rd_release),
    .wr_ready    (wr_ready),
    .rd_avail    (rd_avail),
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank),
    .full_cnt    (full_cnt),
    .err_wr_drop (err_wr_drop),
    .err_rd_drop (err_rd_drop)
  );

  assign wr_row  = wr_data;
  assign wr_fire = wr_en & wr_ready;

  // Banked storage with per-element write enables. The contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < TM; i++) begin
        if (wr_strb[i]) mem_q[wr_bank][wr_addr][i] <= wr_row[i];
      end
    end
  end

  // Stage p1: read from the head bank. Invalid cycles drain zeros to the array.
  always_comb begin
    rd_fire     = rd_en & rd_avail;
    rd_row_p1_d = rd_fire ? mem_q[rd_bank][rd_addr] : '0;
    vld_p1_d    = rd_fire;
  end

  // Stage p1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row_p1_q <= '0;
      vld_p1_q    <= 1'b0;
    end else begin
      rd_row_p1_q <= rd_row_p1_d;
      vld_p1_q    <= vld_p1_d;
    end
  end

`ifdef ACT_BUF_OUT_REG_EN
  row_t rd_row_p2_q, rd_row_p2_d;
  logic vld_p2_q, vld_p2_d;

  // Stage p2: optional output retiming. It is zeroed whenever p1 is empty.
  always_comb begin
    rd_row_p2_d = vld_p1_q ? rd_row_p1_q : '0;
    vld_p2_d    = vld_p1_q;
  end

  // Stage p2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row_p2_q <= '0;
      vld_p2_q    <= 1'b0;
    end else begin
      rd_row_p2_q <= rd_row_p2_d;
      vld_p2_q    <= vld_p2_d;
    end
  end

  assign rd_data       = rd_row_p2_q;
  assign rd_data_valid = vld_p2_q;
`else
  assign rd_data       = rd_row_p1_q;
  assign rd_data_valid = vld_p1_q;
`endif

endmodule

// File: tb/tb_act_buffer_ring.sv
// Directed bench for the ring activation buffer.
module tb_act_buffer_ring;
  import act_buf_pkg::*;

`ifdef ACT_BUF_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ROW_W-1:0]      wr_data;
  logic [TM-1:0]         wr_strb;
  logic                  wr_commit;
  logic                  wr_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_release;
  logic                  rd_avail;
  logic [ROW_W-1:0]      rd_data;
  logic                  rd_data_valid;
  logic [BANK_W-1:0]     wr_bank;
  logic [BANK_W-1:0]     rd_bank;
  logic [CNT_W-1:0]      full_cnt;
  logic                  err_wr_drop;
  logic                  err_rd_drop;

  int n_cmp = 0;
  int n_mis = 0;

  act_buffer_ring dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_commit     (wr_commit),
    .wr_ready      (wr_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_release    (rd_release),
    .rd_avail      (rd_avail),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .full_cnt      (full_cnt),
    .err_wr_drop   (err_wr_drop),
    .err_rd_drop   (err_rd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Element i of row (bank, addr) = bank*32 + addr*4 + i.
  function automatic logic [ROW_W-1:0] pat(input int bank, input int addr);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < TM; i++) r[i*ELEM_W +: ELEM_W] = 8'((bank << 5) + (addr << 2) + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int addr, input logic [ROW_W-1:0] data, input logic [TM-1:0] strb);
    wr_en = 1'b1; wr_addr = ADDR_WIDTH'(addr); wr_data = data; wr_strb = strb;
    tick();
    wr_en = 1'b0; wr_strb = '0;
  endtask

  task automatic pulse_commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [ROW_W-1:0] exp);
    rd_en = 1'b1; rd_addr = ADDR_WIDTH'(addr);
    tick();
    rd_en = 1'b0;
    repeat (RD_LAT - 1) tick();
    chk(tag, rd_data, exp);
    chk({tag, "_vld"}, rd_data_valid, 1'b1);
  endtask

  logic [ROW_W-1:0] strb_exp;
  logic [BANK_W-1:0] bank_exp;
  int lat;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    wr_commit = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_full_cnt", full_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_vld", rd_data_valid, 0);
    chk("rst_err_wr", err_wr_drop, 0);
    chk("rst_err_rd", err_rd_drop, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_avail", rd_avail, 0);
    rst_n = 1'b1;
    tick();

    // Underflow: read and release with nothing committed
    rd_en = 1'b1; rd_addr = 7'd0;
    tick();
    rd_en = 1'b0;
    chk("uf_err_rd", err_rd_drop, 1);
    chk("uf_vld", rd_data_valid, 0);
    chk("uf_data", rd_data, 0);
    tick();
    chk("uf_err_rd_once", err_rd_drop, 0);
    chk("uf_data_late", rd_data, 0);
    pulse_release();
    chk("uf_rel_rd_bank", rd_bank, 0);
    chk("uf_rel_cnt", full_cnt, 0);
    chk("uf_rel_err_rd", err_rd_drop, 1);

    // Fill bank 0 rows 0..3 and commit
    for (int a = 0; a < 4; a++) write_row(a, pat(0, a), '1);
    pulse_commit();
    chk("fill_wr_bank", wr_bank, 1);
    chk("fill_cnt", full_cnt, 1);
    chk("fill_rd_avail", rd_avail, 1);
    chk("fill_err_wr", err_wr_drop, 0);

    // Read row 2 and measure latency
    rd_en = 1'b1; rd_addr = 7'd2;
    tick();
    rd_en = 1'b0;
    lat = 1;
    while (!rd_data_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, RD_LAT);
    chk("rd_row2", rd_data, pat(0, 2));
    tick();
    chk("drain_vld", rd_data_valid, 0);
    chk("drain_data", rd_data, 0);

    // Strobes into bank 1 row 5
    write_row(5, {TM{8'hFF}}, '1);
    write_row(5, ROW_W'(8'hAB), 14'h0001);
    write_row(5, {8'h5C, {(ROW_W-8){1'b0}}}, 14'h2000);
    pulse_commit();
    chk("strb_commit_cnt", full_cnt, 2);

    // Write+commit+release+read in one cycle
    wr_en = 1'b1; wr_addr = 7'd1; wr_data = pat(2, 1); wr_strb = '1; wr_commit = 1'b1;
    rd_en = 1'b1; rd_addr = 7'd2; rd_release = 1'b1;
    tick();
    wr_en = 1'b0; wr_strb = '0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    chk("sim_cnt", full_cnt, 2);
    chk("sim_wr_bank", wr_bank, 3);
    chk("sim_rd_bank", rd_bank, 1);
    repeat (RD_LAT - 1) tick();
    chk("sim_rd_old_bank", rd_data, pat(0, 2));

    strb_exp = {TM{8'hFF}};
    strb_exp[7:0] = 8'hAB;
    strb_exp[ROW_W-1 -: 8] = 8'h5C;
    read_chk("strb_row", 5, strb_exp);
    pulse_release();
    chk("rel_rd_bank", rd_bank, 2);
    chk("rel_cnt", full_cnt, 1);
    read_chk("wr_commit_old_bank", 1, pat(2, 1));

    // Overflow
    pulse_commit();
    pulse_commit();
    chk("ov_cnt3", full_cnt, 3);
    chk("ov_ready3", wr_ready, 1);
    pulse_commit();
    chk("ov_cnt4", full_cnt, 4);
    chk("ov_ready4", wr_ready, 0);
    chk("ov_wr_bank", wr_bank, 2);
    write_row(1, '0, '1);
    chk("ov_err_wr", err_wr_drop, 1);
    tick();
    chk("ov_err_wr_once", err_wr_drop, 0);
    pulse_commit();
    chk("ov_commit_err", err_wr_drop, 1);
    chk("ov_commit_wr_bank", wr_bank, 2);
    chk("ov_commit_cnt", full_cnt, 4);
    chk("ov_rd_bank", rd_bank, 2);
    read_chk("ov_mem_kept", 1, pat(2, 1));

    // Reset in the middle of a read burst
    rd_en = 1'b1; rd_addr = 7'd0;
    tick();
    rd_addr = 7'd1;
    repeat (RD_LAT) tick();
    chk("burst_vld", rd_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", rd_data, 0);
    chk("mrst_vld", rd_data_valid, 0);
    chk("mrst_cnt", full_cnt, 0);
    chk("mrst_wr_bank", wr_bank, 0);
    chk("mrst_rd_bank", rd_bank, 0);
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_ready", wr_ready, 1);

    // Pointer wrap over five commit/release pairs
    for (int i = 0; i < 5; i++) begin
      pulse_commit();
      pulse_release();
      bank_exp = BANK_W'(i + 1);
      chk("wrap_wr_step", wr_bank, bank_exp);
    end
    chk("wrap_wr_bank", wr_bank, 1);
    chk("wrap_rd_bank", rd_bank, 1);
    chk("wrap_cnt", full_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
